// File: rtl/traffic_phase_timer_if.sv
// Request/response bundle between traffic_lights and the phase timer.
// The controller side is master; the timer side is slave.
interface traffic_phase_timer_if #(
  parameter int CNT_W = 8
);
  logic             short_counter;
  logic             long_counter;
  logic             i_hold;
  logic             counter_done;
  logic             o_busy;
  logic             o_active_long;
  logic [CNT_W-1:0] o_remaining;

  modport master (
    output short_counter,
    output long_counter,
    output i_hold,
    input  counter_done,
    input  o_busy,
    input  o_active_long,
    input  o_remaining
  );

  modport slave (
    input  short_counter,
    input  long_counter,
    input  i_hold,
    output counter_done,
    output o_busy,
    output o_active_long,
    output o_remaining
  );
endinterface

// File: rtl/traffic_phase_timer.sv
// Phase-duration timer: times short/long phases in prescaled ticks
// and pulses counter_done on expiry; supports hold and abort.
module traffic_phase_timer #(
  parameter int SHORT_CYCLES = 15,
  parameter int LONG_CYCLES  = 63,
  parameter int TICK_DIV     = 1,
  parameter int CNT_W        = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  traffic_phase_timer_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]    PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_nx;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_nx;
  logic             lng;
  logic             lng_nx;
  logic             busy;
  logic             busy_nx;
  logic             done;
  logic             done_nx;

  logic req_any;
  logic req_act;
  logic abort;
  logic tick;
  logic expire;

  assign req_any = bus.long_counter | bus.short_counter;
  assign req_act = lng ? bus.long_counter
                       : bus.short_counter;
  assign abort   = (state == RUN) && !req_act;
  assign tick    = (state == RUN) && !bus.i_hold
                && (presc == PRE_MAX);
  assign expire  = tick && (rem == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Abort outranks an expiring tick in the same cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req_any) state_nx = RUN;
      RUN: begin
        if (abort)       state_nx = IDLE;
        else if (expire) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    presc_nx = presc;
    rem_nx   = rem;
    lng_nx   = lng;
    busy_nx  = busy;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        presc_nx = '0;
        rem_nx   = '0;
        lng_nx   = 1'b0;
        busy_nx  = 1'b0;
        priority case (1'b1)
          bus.long_counter: begin
            rem_nx  = LONG_LD;
            lng_nx  = 1'b1;
            busy_nx = 1'b1;
          end
          bus.short_counter: begin
            rem_nx  = SHORT_LD;
            lng_nx  = 1'b0;
            busy_nx = 1'b1;
          end
          default: ;
        endcase
      end
      RUN: begin
        if (abort) begin
          presc_nx = '0;
          rem_nx   = '0;
          lng_nx   = 1'b0;
          busy_nx  = 1'b0;
        end else if (!bus.i_hold) begin
          if (tick) begin
            presc_nx = '0;
            if (rem == '0) begin
              done_nx = 1'b1;
              busy_nx = 1'b0;
            end else begin
              rem_nx = rem - CNT_W'(1);
            end
          end else begin
            presc_nx = presc + PW'(1);
          end
        end
      end
      DONE: begin
        presc_nx = '0;
        rem_nx   = '0;
        lng_nx   = 1'b0;
        busy_nx  = 1'b0;
      end
      default: begin
        presc_nx = '0;
        rem_nx   = '0;
        lng_nx   = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      rem   <= '0;
      lng   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      presc <= presc_nx;
      rem   <= rem_nx;
      lng   <= lng_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  assign bus.counter_done  = done;
  assign bus.o_busy        = busy;
  assign bus.o_active_long = lng;
  assign bus.o_remaining   = rem;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Scoreboard bench for traffic_phase_timer: two builds, directed
// scenarios plus random request/hold traffic against a tick model.
module tb_traffic_phase_timer;

  localparam int CW = 8;
  localparam int SC_A = 15;
  localparam int LC_A = 63;
  localparam int TD_A = 1;
  localparam int SC_B = 3;
  localparam int LC_B = 5;
  localparam int TD_B = 4;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;

  traffic_phase_timer_if #(.CNT_W(CW)) ifa ();
  traffic_phase_timer_if #(.CNT_W(CW)) ifb ();

  traffic_phase_timer #(
    .SHORT_CYCLES(SC_A), .LONG_CYCLES(LC_A),
    .TICK_DIV(TD_A), .CNT_W(CW)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(ifa)
  );

  traffic_phase_timer #(
    .SHORT_CYCLES(SC_B), .LONG_CYCLES(LC_B),
    .TICK_DIV(TD_B), .CNT_W(CW)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(ifb)
  );

  always #5 clk = ~clk;

  // ph: 0 idle, 1 timing, 2 done; act counts un-held run cycles
  typedef struct {
    int ph;
    bit lg;
    int n;
    int act;
  } mdl_t;

  typedef struct {
    int cyc;
    bit lg;
  } exp_t;

  mdl_t ma;
  mdl_t mb;
  exp_t qa[$];
  exp_t qb[$];
  int   cyc_a = 0;
  int   cyc_b = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // A phase of n ticks expires after n*td un-held running cycles.
  function automatic mdl_t step(input mdl_t m, input bit l,
                                input bit s, input bit h,
                                input int sc, input int lc,
                                input int td, output bit fin);
    mdl_t r;
    r   = m;
    fin = 1'b0;
    case (m.ph)
      0: begin
        if (l) begin
          r.ph = 1; r.lg = 1'b1; r.n = lc; r.act = 0;
        end else if (s) begin
          r.ph = 1; r.lg = 1'b0; r.n = sc; r.act = 0;
        end
      end
      1: begin
        if (!(m.lg ? l : s)) begin
          r.ph = 0;
        end else if (!h) begin
          r.act = m.act + 1;
          if (r.act == m.n * td) begin
            r.ph = 2;
            fin  = 1'b1;
          end
        end
      end
      default: r.ph = 0;
    endcase
    return r;
  endfunction

  function automatic int exp_rem(input mdl_t m, input int td);
    return (m.ph == 1) ? (m.n - 1 - m.act / td) : 0;
  endfunction

  always @(posedge clk or negedge rst_n_a) begin : model_a
    bit f;
    if (!rst_n_a) begin
      ma = '{0, 1'b0, 0, 0};
      qa.delete();
    end else begin
      cyc_a++;
      ma = step(ma, ifa.long_counter, ifa.short_counter,
                ifa.i_hold, SC_A, LC_A, TD_A, f);
      if (f) qa.push_back('{cyc_a, ma.lg});
    end
  end

  always @(posedge clk or negedge rst_n_b) begin : model_b
    bit f;
    if (!rst_n_b) begin
      mb = '{0, 1'b0, 0, 0};
      qb.delete();
    end else begin
      cyc_b++;
      mb = step(mb, ifb.long_counter, ifb.short_counter,
                ifb.i_hold, SC_B, LC_B, TD_B, f);
      if (f) qb.push_back('{cyc_b, mb.lg});
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n_a) begin
      chk("a_done", int'(ifa.counter_done), int'(ma.ph == 2));
      chk("a_busy", int'(ifa.o_busy), int'(ma.ph == 1));
      chk("a_long", int'(ifa.o_active_long),
          int'(ma.ph != 0 && ma.lg));
      chk("a_rem", int'(ifa.o_remaining), exp_rem(ma, TD_A));
      if (ifa.counter_done) begin
        if (qa.size() == 0) begin
          chk("a_sb_spurious", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_sb_cyc", cyc_a, e.cyc);
          chk("a_sb_long", int'(ifa.o_active_long), int'(e.lg));
        end
      end
    end
    if (rst_n_b) begin
      chk("b_done", int'(ifb.counter_done), int'(mb.ph == 2));
      chk("b_busy", int'(ifb.o_busy), int'(mb.ph == 1));
      chk("b_long", int'(ifb.o_active_long),
          int'(mb.ph != 0 && mb.lg));
      chk("b_rem", int'(ifb.o_remaining), exp_rem(mb, TD_B));
      if (ifb.counter_done) begin
        if (qb.size() == 0) begin
          chk("b_sb_spurious", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_sb_cyc", cyc_b, e.cyc);
          chk("b_sb_long", int'(ifb.o_active_long), int'(e.lg));
        end
      end
    end
  end

  task automatic wait_done(input bit sel, output int n);
    n = -1;
    for (int i = 1; i <= 500; i++) begin
      @(negedge clk);
      if (sel ? ifb.counter_done : ifa.counter_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic idle_all(input int cycles);
    ifa.long_counter  = 1'b0;
    ifa.short_counter = 1'b0;
    ifa.i_hold        = 1'b0;
    ifb.long_counter  = 1'b0;
    ifb.short_counter = 1'b0;
    ifb.i_hold        = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin : main
    int n;
    int cnt;
    int r;
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    ifa.long_counter  = 1'b0;
    ifa.short_counter = 1'b0;
    ifa.i_hold        = 1'b0;
    ifb.long_counter  = 1'b0;
    ifb.short_counter = 1'b0;
    ifb.i_hold        = 1'b0;
    #1;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    ifa.long_counter = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_done", int'(ifa.counter_done), 0);
    chk("rst_busy", int'(ifa.o_busy), 0);
    chk("rst_long", int'(ifa.o_active_long), 0);
    chk("rst_rem", int'(ifa.o_remaining), 0);
    chk("rst_b_busy", int'(ifb.o_busy), 0);

    // 1: held long request, latency and repeat period
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    wait_done(1'b0, n);
    chk("t1_latency", n - 1, 63);
    wait_done(1'b0, n);
    chk("t1_period", n, 65);
    idle_all(3);

    // 2: short phase
    ifa.short_counter = 1'b1;
    @(negedge clk);
    chk("t2_rem0", int'(ifa.o_remaining), 14);
    chk("t2_long", int'(ifa.o_active_long), 0);
    chk("t2_busy", int'(ifa.o_busy), 1);
    wait_done(1'b0, n);
    chk("t2_latency", n, 15);
    idle_all(3);

    // 3: both requests on the same edge
    ifa.short_counter = 1'b1;
    ifa.long_counter  = 1'b1;
    @(negedge clk);
    chk("t3_rem0", int'(ifa.o_remaining), 62);
    chk("t3_long", int'(ifa.o_active_long), 1);
    idle_all(3);

    // 4: abort a long phase, short request waiting
    ifa.long_counter = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifa.o_remaining == CW'(30)) break;
    end
    chk("t4_reach30", int'(ifa.o_remaining), 30);
    ifa.long_counter  = 1'b0;
    ifa.short_counter = 1'b1;
    @(negedge clk);
    chk("t4_abort_busy", int'(ifa.o_busy), 0);
    chk("t4_abort_rem", int'(ifa.o_remaining), 0);
    chk("t4_abort_done", int'(ifa.counter_done), 0);
    @(negedge clk);
    chk("t4_short_busy", int'(ifa.o_busy), 1);
    chk("t4_short_rem", int'(ifa.o_remaining), 14);
    chk("t4_short_long", int'(ifa.o_active_long), 0);
    idle_all(3);

    // 5: hold for five cycles mid-run
    ifa.long_counter = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt++;
    end
    r = int'(ifa.o_remaining);
    ifa.i_hold = 1'b1;
    repeat (5) begin
      @(negedge clk);
      cnt++;
      chk("t5_hold_rem", int'(ifa.o_remaining), r);
    end
    ifa.i_hold = 1'b0;
    wait_done(1'b0, n);
    cnt += n;
    chk("t5_latency", (n < 0) ? -1 : cnt - 1, 68);
    idle_all(3);

    // 6: prescaled build, then async reset mid-run
    ifb.short_counter = 1'b1;
    wait_done(1'b1, n);
    chk("t6_latency", n - 1, 12);
    idle_all(3);
    ifb.short_counter = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    chk("t6_pre_busy", int'(ifb.o_busy), 1);
    #1;
    rst_n_b = 1'b0;
    #1;
    chk("t6_rst_busy", int'(ifb.o_busy), 0);
    chk("t6_rst_rem", int'(ifb.o_remaining), 0);
    chk("t6_rst_done", int'(ifb.counter_done), 0);
    chk("t6_rst_long", int'(ifb.o_active_long), 0);
    @(negedge clk);
    ifb.short_counter = 1'b0;
    repeat (2) @(negedge clk);
    rst_n_b = 1'b1;
    idle_all(3);

    // random request / hold traffic on both builds
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 79) == 0)
        ifa.long_counter = ~ifa.long_counter;
      if ($urandom_range(0, 29) == 0)
        ifa.short_counter = ~ifa.short_counter;
      if ($urandom_range(0, 11) == 0)
        ifa.i_hold = ~ifa.i_hold;
      if ($urandom_range(0, 39) == 0)
        ifb.long_counter = ~ifb.long_counter;
      if ($urandom_range(0, 24) == 0)
        ifb.short_counter = ~ifb.short_counter;
      if ($urandom_range(0, 9) == 0)
        ifb.i_hold = ~ifb.i_hold;
    end
    idle_all(6);
    chk("a_sb_drained", qa.size(), 0);
    chk("b_sb_drained", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
